// File: rtl/riscv_axi_rd_arb.sv
// AXI4 read-channel arbiter. It merges NUM_REQ requester AR/R port pairs onto one master
// read port, tags ARID with the requester index, and routes R beats back by that tag.
module riscv_axi_rd_arb #(
  parameter int  NUM_REQ         = 2,
  parameter int  ADDR_W          = 32,
  parameter int  DATA_W          = 32,
  parameter int  ID_W            = 4,
  parameter int  MAX_OUTSTANDING = 4,
  localparam int IDX_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int MID_W           = ID_W + IDX_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_arvalid,
  output logic [NUM_REQ-1:0]        req_arready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  input  logic [NUM_REQ*ID_W-1:0]   req_arid,
  input  logic [NUM_REQ*8-1:0]      req_arlen,
  output logic [NUM_REQ-1:0]        req_rvalid,
  input  logic [NUM_REQ-1:0]        req_rready,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [ID_W-1:0]           req_rid,
  output logic [1:0]                req_rresp,
  output logic                      req_rlast,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [MID_W-1:0]          m_arid,
  output logic [7:0]                m_arlen,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [MID_W-1:0]          m_rid,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  output logic                      err_unrouted,
  output logic                      outstanding_any
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]   count [NUM_REQ];
  logic [IDX_W-1:0]   rr_ptr;
  logic               run_q;
  logic               load_en;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic [ADDR_W-1:0]  win_addr;
  logic [ID_W-1:0]    win_id;
  logic [7:0]         win_len;
  logic [IDX_W-1:0]   r_idx;
  logic               r_routed;
  logic [NUM_REQ-1:0] r_done;

  // Grants open one cycle after reset release, so the deassertion is always taken on a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  assign load_en = run_q && (!m_arvalid || m_arready);

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_arvalid[i] && (count[i] != CNT_MAX);
  end

  // Round-robin search starting at rr_ptr; the first eligible requester wins.
  always_comb begin
    int cand;
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    next_ptr    = rr_ptr;
    win_addr    = '0;
    win_id      = '0;
    win_len     = '0;
    req_arready = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (int'(rr_ptr) + off) % NUM_REQ;
      if (load_en && !grant_valid && eligible[cand]) begin
        grant_valid       = 1'b1;
        grant_idx         = IDX_W'(cand);
        next_ptr          = IDX_W'((cand + 1) % NUM_REQ);
        win_addr          = req_araddr[cand*ADDR_W +: ADDR_W];
        win_id            = req_arid[cand*ID_W +: ID_W];
        win_len           = req_arlen[cand*8 +: 8];
        req_arready[cand] = 1'b1;
      end
    end
  end

  // Single-entry AR output register; contents only move when the slot is free or draining.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arid    <= '0;
      m_arlen   <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      m_arvalid <= grant_valid;
      if (grant_valid) begin
        m_araddr <= win_addr;
        m_arid   <= {grant_idx, win_id};
        m_arlen  <= win_len;
        rr_ptr   <= next_ptr;
      end
    end
  end

  assign r_idx = m_rid[MID_W-1:ID_W];

  // Route by the index tag; beats tagged beyond NUM_REQ are accepted and dropped.
  always_comb begin
    r_routed   = 1'b0;
    req_rvalid = '0;
    m_rready   = 1'b1;
    r_done     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(r_idx) == i) begin
        r_routed      = 1'b1;
        req_rvalid[i] = m_rvalid;
        m_rready      = req_rready[i];
        r_done[i]     = m_rvalid && req_rready[i] && m_rlast;
      end
    end
  end

  // NOTE: the counter array is control state, so unlike a data RAM it must be reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_arready[i] && !r_done[i])
          count[i] <= count[i] + 1'b1;
        else if (r_done[i] && !req_arready[i] && count[i] != '0)
          count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_unrouted <= 1'b0;
    else          err_unrouted <= m_rvalid && !r_routed;
  end

  always_comb begin
    outstanding_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (count[i] != '0) outstanding_any = 1'b1;
  end

  assign req_rdata = m_rdata;
  assign req_rid   = m_rid[ID_W-1:0];
  assign req_rresp = m_rresp;
  assign req_rlast = m_rlast;

endmodule

// File: tb/tb_riscv_axi_rd_arb.sv
// Self-checking bench for riscv_axi_rd_arb. It uses directed corner-case sequences, a
// routing vector table, and randomized traffic checked against a behavioural model.
module tb_riscv_axi_rd_arb;
  localparam int N    = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int IW   = 4;
  localparam int MAXO = 2;
  localparam int XW   = 2;
  localparam int MW   = IW + XW;

  logic            clock;
  logic            reset_n;
  logic [N-1:0]    req_arvalid, req_arready, req_rvalid, req_rready;
  logic [N*AW-1:0] req_araddr;
  logic [N*IW-1:0] req_arid;
  logic [N*8-1:0]  req_arlen;
  logic [DW-1:0]   req_rdata;
  logic [IW-1:0]   req_rid;
  logic [1:0]      req_rresp;
  logic            req_rlast;
  logic            m_arvalid, m_arready;
  logic [AW-1:0]   m_araddr;
  logic [MW-1:0]   m_arid;
  logic [7:0]      m_arlen;
  logic            m_rvalid, m_rready;
  logic [DW-1:0]   m_rdata;
  logic [MW-1:0]   m_rid;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            err_unrouted, outstanding_any;

  riscv_axi_rd_arb #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_arvalid(req_arvalid), .req_arready(req_arready), .req_araddr(req_araddr),
    .req_arid(req_arid), .req_arlen(req_arlen),
    .req_rvalid(req_rvalid), .req_rready(req_rready), .req_rdata(req_rdata),
    .req_rid(req_rid), .req_rresp(req_rresp), .req_rlast(req_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arid(m_arid), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .err_unrouted(err_unrouted), .outstanding_any(outstanding_any)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: bursts in flight per requester, the next requester in line, one AR slot.
  int            mdl_cnt [N];
  int            mdl_ptr;
  bit            mdl_run;
  bit            mdl_arv;
  logic [AW-1:0] mdl_addr;
  logic [MW-1:0] mdl_id;
  logic [7:0]    mdl_len;
  bit            mdl_err;

  task automatic model_reset();
    for (int i = 0; i < N; i++) mdl_cnt[i] = 0;
    mdl_ptr = 0; mdl_run = 0; mdl_arv = 0;
    mdl_addr = '0; mdl_id = '0; mdl_len = '0; mdl_err = 0;
  endtask

  function automatic int pick_winner();
    if (!mdl_run || (mdl_arv && !m_arready)) return -1;
    for (int off = 0; off < N; off++) begin
      int c;
      c = (mdl_ptr + off) % N;
      if (req_arvalid[c] && mdl_cnt[c] < MAXO) return c;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    int           w, idx;
    logic [N-1:0] exp_arr, exp_rv;
    logic         exp_mr;
    bit           any;
    w = pick_winner();
    exp_arr = '0;
    if (w >= 0) exp_arr[w] = 1'b1;
    check("req_arready", req_arready, exp_arr);
    check("m_arvalid", m_arvalid, mdl_arv);
    check("m_araddr", m_araddr, mdl_addr);
    check("m_arid", m_arid, mdl_id);
    check("m_arlen", m_arlen, mdl_len);
    idx = int'(m_rid[MW-1:IW]);
    exp_rv = '0;
    exp_mr = 1'b1;
    if (idx < N) begin
      exp_rv[idx] = m_rvalid;
      exp_mr      = req_rready[idx];
    end
    check("req_rvalid", req_rvalid, exp_rv);
    check("m_rready", m_rready, exp_mr);
    check("req_rid", req_rid, m_rid[IW-1:0]);
    check("req_rdata", req_rdata, m_rdata);
    check("req_rresp", req_rresp, m_rresp);
    check("req_rlast", req_rlast, m_rlast);
    check("err_unrouted", err_unrouted, mdl_err);
    any = 0;
    for (int i = 0; i < N; i++) if (mdl_cnt[i] != 0) any = 1;
    check("outstanding_any", outstanding_any, any);
  endtask

  task automatic model_step();
    int w, idx;
    bit le, rhs;
    w   = pick_winner();
    le  = mdl_run && (!mdl_arv || m_arready);
    idx = int'(m_rid[MW-1:IW]);
    rhs = m_rvalid && ((idx >= N) ? 1'b1 : req_rready[idx]);
    if (w >= 0) mdl_cnt[w]++;
    if (rhs && m_rlast && idx < N && mdl_cnt[idx] > 0) mdl_cnt[idx]--;
    if (le) begin
      mdl_arv = (w >= 0);
      if (w >= 0) begin
        mdl_addr = req_araddr[w*AW +: AW];
        mdl_id   = {XW'(w), req_arid[w*IW +: IW]};
        mdl_len  = req_arlen[w*8 +: 8];
        mdl_ptr  = (w + 1) % N;
      end
    end
    mdl_err = m_rvalid && (idx >= N);
    mdl_run = 1;
  endtask

  task automatic settle();
    #1;
    check_outputs();
  endtask

  task automatic advance();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic apply_reset();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_m_arvalid", m_arvalid, 1'b0);
    check("rst_req_arready", req_arready, '0);
    check("rst_outstanding", outstanding_any, 1'b0);
    check("rst_err", err_unrouted, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic expect_first_grant(input string tag);
    int n;
    n = 0;
    settle();
    while (!m_arvalid && n < 8) begin
      advance();
      settle();
      n++;
    end
    check({tag, "_seen"}, m_arvalid, 1'b1);
    check({tag, "_idx"}, m_arid[MW-1:IW], 0);
  endtask

  typedef struct {
    logic          rvalid;
    logic [MW-1:0] rid;
    logic [N-1:0]  rready;
    logic [N-1:0]  exp_rvalid;
    logic          exp_mready;
    logic [IW-1:0] exp_rid;
  } rt_vec_t;

  rt_vec_t tbl [9];

  initial begin
    int seq [$];
    int prev_hs, beat;

    tbl[0] = '{1'b1, {2'd0, 4'h3}, 3'b001, 3'b001, 1'b1, 4'h3};
    tbl[1] = '{1'b1, {2'd0, 4'h3}, 3'b110, 3'b001, 1'b0, 4'h3};
    tbl[2] = '{1'b1, {2'd1, 4'hF}, 3'b010, 3'b010, 1'b1, 4'hF};
    tbl[3] = '{1'b1, {2'd2, 4'h0}, 3'b011, 3'b100, 1'b0, 4'h0};
    tbl[4] = '{1'b1, {2'd2, 4'h7}, 3'b100, 3'b100, 1'b1, 4'h7};
    tbl[5] = '{1'b0, {2'd1, 4'h2}, 3'b111, 3'b000, 1'b1, 4'h2};
    tbl[6] = '{1'b0, {2'd0, 4'h1}, 3'b000, 3'b000, 1'b0, 4'h1};
    tbl[7] = '{1'b1, {2'd3, 4'h9}, 3'b000, 3'b000, 1'b1, 4'h9};
    tbl[8] = '{1'b0, {2'd3, 4'h9}, 3'b000, 3'b000, 1'b1, 4'h9};

    reset_n = 1'b1;
    req_arvalid = '0; req_rready = '0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
    m_rid = '0; m_rdata = '0; m_rresp = '0;
    req_araddr = {32'h3000_0100, 32'h2000_0080, 32'h1000_0040};
    req_arid   = {4'h9, 4'hC, 4'h3};
    req_arlen  = {8'd1, 8'd3, 8'd7};

    // Reset, first grant, then an asynchronous reset with a burst pending and the pointer moved on.
    req_arvalid = 3'b111;
    apply_reset();
    expect_first_grant("first_grant");
    m_arready = 1'b1;
    advance();
    m_arready = 1'b0;
    settle();
    check("pre_rst_arvalid", m_arvalid, 1'b1);
    check("pre_rst_outstanding", outstanding_any, 1'b1);
    apply_reset();
    expect_first_grant("post_rst_grant");
    advance();

    // Round robin between requesters 0 and 1 with m_arready held high.
    req_arvalid = 3'b011;
    m_arready = 1'b1;
    apply_reset();
    prev_hs = -1;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (prev_hs >= 0) begin
        check("ar_latency_valid", m_arvalid, 1'b1);
        check("ar_latency_idx", m_arid[MW-1:IW], prev_hs);
      end
      if (m_arvalid) seq.push_back(int'(m_arid[MW-1:IW]));
      prev_hs = onehot_idx(req_arready);
      advance();
    end
    check("rr_burst_count", seq.size(), 4);
    for (int k = 0; k < 4; k++)
      check("rr_order", (k < seq.size()) ? seq[k] : -1, k % 2);

    // Backpressure: the captured burst holds while m_arready is low.
    req_arvalid = 3'b001;
    m_arready = 1'b0;
    apply_reset();
    cycle();
    cycle();
    req_arvalid = 3'b110;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("bp_valid", m_arvalid, 1'b1);
      check("bp_addr", m_araddr, 32'h1000_0040);
      check("bp_id", m_arid, {2'd0, 4'h3});
      check("bp_len", m_arlen, 8'd7);
      check("bp_arready", req_arready, 3'b000);
      advance();
    end
    m_arready = 1'b1;
    settle();
    check("bp_release_grant", req_arready, 3'b010);
    advance();
    settle();
    check("bp_next_idx", m_arid[MW-1:IW], 1);
    check("bp_next_addr", m_araddr, 32'h2000_0080);
    advance();

    // Outstanding limit on requester 1, then release by an rlast beat tagged 1.
    req_arvalid = 3'b010;
    apply_reset();
    cycle();
    settle(); check("lim_g1", req_arready, 3'b010); advance();
    settle(); check("lim_g2", req_arready, 3'b010); advance();
    settle(); check("lim_stall", req_arready, 3'b000); advance();
    req_arvalid = 3'b011;
    settle(); check("lim_other1", req_arready, 3'b001); advance();
    settle(); check("lim_other2", req_arready, 3'b001); advance();
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = {2'd1, 4'h5}; req_rready = 3'b010;
    settle(); check("lim_still_blocked", req_arready[1], 1'b0); advance();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle(); check("lim_unblocked", req_arready, 3'b010); advance();

    // Four-beat burst to requester 1 with its ready toggling.
    req_arvalid = 3'b010;
    beat = 0;
    for (int c = 0; c < 12 && beat < 4; c++) begin
      req_rready = (c % 2 == 1) ? 3'b010 : 3'b101;
      m_rvalid = 1'b1;
      m_rlast = (beat == 3);
      m_rdata = 32'hA000_0000 + beat;
      settle();
      check("rt_rvalid", req_rvalid, 3'b010);
      check("rt_mready", m_rready, req_rready[1]);
      check("rt_rid", req_rid, 4'h5);
      check("rt_blocked", req_arready[1], 1'b0);
      if (req_rready[1]) beat++;
      advance();
    end
    check("rt_beats", beat, 4);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle(); check("rt_unblock", req_arready[1], 1'b1); advance();
    req_arvalid = 3'b000;

    // Unrouted beat: sunk, flagged for one cycle, and no counter is touched.
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = {2'd3, 4'hA}; req_rready = 3'b000;
    settle();
    check("un_mready", m_rready, 1'b1);
    check("un_rvalid", req_rvalid, 3'b000);
    check("un_err_before", err_unrouted, 1'b0);
    advance();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rid = '0;
    settle();
    check("un_err_pulse", err_unrouted, 1'b1);
    check("un_outstanding", outstanding_any, 1'b1);
    advance();
    req_arvalid = 3'b001;
    settle();
    check("un_err_clear", err_unrouted, 1'b0);
    check("un_cnt0_still_full", req_arready, 3'b000);
    advance();
    req_arvalid = 3'b000;

    // Routing vector table.
    apply_reset();
    for (int v = 0; v < 9; v++) begin
      m_rvalid = tbl[v].rvalid;
      m_rid = tbl[v].rid;
      req_rready = tbl[v].rready;
      m_rlast = 1'b0;
      settle();
      check("tbl_rvalid", req_rvalid, tbl[v].exp_rvalid);
      check("tbl_mready", m_rready, tbl[v].exp_mready);
      check("tbl_rid", req_rid, tbl[v].exp_rid);
      advance();
    end

    // Randomized traffic against the model.
    m_rvalid = 1'b0;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      req_arvalid = N'($urandom);
      req_araddr  = {$urandom, $urandom, $urandom};
      req_arid    = (N*IW)'($urandom);
      req_arlen   = (N*8)'($urandom);
      m_arready   = ($urandom % 4) != 0;
      m_rvalid    = $urandom % 2;
      m_rid       = {(($urandom % 8) == 0) ? 2'd3 : XW'($urandom % N), IW'($urandom)};
      m_rlast     = $urandom % 2;
      m_rdata     = $urandom;
      m_rresp     = 2'($urandom);
      req_rready  = N'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_axi_rd_arb.md
Name: riscv_axi_rd_arb

Overview:
- Parametrised AXI4 read-channel arbiter. Merges NUM_REQ requester AR/R port pairs (IFU, LSU, future prefetch/PTW) onto the single core AXI read master port.
- Tags each burst's ARID with the requester index and routes R beats back by that tag.
- Tracks outstanding bursts per requester.
- Successor to the single-IFU direct connection. Instantiated in riscv_top between the requesters and AXI_AR_M/AXI_R_S.

Parameters:
- NUM_REQ, 2, number of requester ports (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- ID_W, 4, requester-side ID width.
- MAX_OUTSTANDING, 4, maximum in-flight bursts per requester (1..15).
- Derived: IDX_W = max(1, clog2(NUM_REQ)); master ID width MID_W = ID_W+IDX_W.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- req_arvalid  in  NUM_REQ  per-requester AR valid.
- req_arready  out  NUM_REQ  per-requester AR ready.
- req_araddr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_arid  in  NUM_REQ*ID_W  packed IDs.
- req_arlen  in  NUM_REQ*8  packed burst lengths.
- req_rvalid  out  NUM_REQ  per-requester R valid.
- req_rready  in  NUM_REQ  per-requester R ready.
- req_rdata  out  DATA_W  R data, broadcast to all requesters.
- req_rid  out  ID_W  low ID_W bits of m_rid.
- req_rresp  out  2  broadcast response.
- req_rlast  out  1  broadcast last.
- m_arvalid, m_arready  out/in  1  master AR handshake.
- m_araddr  out  ADDR_W.
- m_arid  out  MID_W  {requester index, requester ID}.
- m_arlen  out  8.
- m_rvalid, m_rready  in/out  1  master R handshake.
- m_rdata  in  DATA_W.
- m_rid  in  MID_W.
- m_rresp  in  2.
- m_rlast  in  1.
- err_unrouted  out  1  one-cycle pulse when an R beat carries an index >= NUM_REQ.
- outstanding_any  out  1  high when any counter is nonzero.

Behaviour:
- Reset (reset_n low, asynchronous):
  - m_arvalid=0; m_araddr/m_arid/m_arlen=0.
  - RR pointer=0; all counters=0.
  - err_unrouted=0; outstanding_any=0; req_arready=0.
  - Deassertion is taken synchronously to clock. Reset mid-burst discards all tracking.
- AR output register (single entry):
  - load_en = !m_arvalid || m_arready.
  - When load_en and an eligible requester exists, capture the winner's addr/len and {idx,id}; set m_arvalid next cycle.
  - If load_en with no winner and m_arready, m_arvalid drops next cycle.
  - m_ar* are held stable while m_arvalid && !m_arready.
- Eligibility: req_arvalid[i] && count[i] != MAX_OUTSTANDING.
- Arbitration:
  - Round robin. Search starts at pointer and wraps modulo NUM_REQ.
  - Grant only when load_en.
  - req_arready is one-hot at the grantee only, and all zero otherwise. It is combinational from req_arvalid, counters, pointer and load_en.
  - After a grant to i, pointer = (i+1) mod NUM_REQ. Pointer is unchanged when there is no grant.
- Latency and throughput:
  - Requester AR handshake to m_arvalid: 1 cycle.
  - Sustained throughput: 1 burst per cycle when m_arready is held high.
- Counters:
  - count[i] increments on a requester i AR handshake.
  - count[i] decrements on a master R handshake with m_rlast where m_rid[MID_W-1:ID_W]==i.
  - Simultaneous increment and decrement leaves the count unchanged.
  - Decrement at 0 is an error; the count saturates at 0 (assertion in the bench).
  - outstanding_any = OR of (count != 0).
- R routing (combinational, zero latency):
  - idx = m_rid[MID_W-1:ID_W].
  - If idx < NUM_REQ: req_rvalid[idx] = m_rvalid, other req_rvalid=0, m_rready = req_rready[idx].
  - If idx >= NUM_REQ: all req_rvalid=0, m_rready=1 (beat sunk), err_unrouted registered high for 1 cycle per sunk beat.
  - Data, resp, last and the low ID bits are broadcast unregistered.
- No reordering is imposed. Per-ID ordering is the slave's responsibility.
- NUM_REQ=1: IDX_W=1 and the index bit is always 0; m_rid index 1 is unrouted.

Test Plan:
- Reset sequence:
  - Assert reset_n=0 mid-transfer with m_arvalid=1.
  - m_arvalid=0 and all counters 0 immediately (asynchronous).
  - First grant after release goes to requester 0.
- Round robin:
  - NUM_REQ=2, both requesters hold arvalid, m_arready=1 constantly.
  - m_arid index sequence is 0,1,0,1; one burst per cycle.
  - Each AR appears 1 cycle after its handshake.
- Backpressure:
  - m_arready=0 for 5 cycles with m_arvalid=1.
  - m_araddr/m_arid/m_arlen stable.
  - req_arready all 0 throughout.
  - The pending grant issues in the cycle m_arready returns.
- Outstanding limit:
  - MAX_OUTSTANDING=2; requester 1 issues 2 bursts with no R traffic.
  - The third request is stalled (req_arready[1]=0) while requester 0 keeps being granted.
  - An R beat with rlast and index 1 unblocks requester 1 the next cycle.
- R routing:
  - m_rid={1, ID 0x5}, 4-beat burst, req_rready[1] toggling.
  - req_rvalid[1] mirrors m_rvalid; m_rready follows req_rready[1]; req_rid=0x5.
  - count[1] decrements only on the rlast beat.
- Unrouted response:
  - NUM_REQ=3, m_rid index 3, m_rvalid=1.
  - m_rready=1, all req_rvalid=0, err_unrouted pulses 1 cycle.
  - Counters unchanged.
